// File: rtl/i2s_mic_rx_ctrl_if.sv
// I2S microphone receiver bus.
// Bundles the controller's pin-side and datapath-side signals.
//   enable       : level, high = run the interface (driven by the datapath)
//   sdo          : mic serial data, already synchronized
//   sck, ws      : I2S bit clock and word select to the mic
//   sample       : signed captured sample, SAMPLE_BITS wide
//   sample_16    : top 16 bits of sample (right zero-padded when narrower)
//   sample_valid : one-clk pulse when sample updates
//   running      : high while samples are being delivered
// SAMPLE_BITS must match the controller instance it connects to.
interface i2s_mic_rx_ctrl_if #(
  parameter int unsigned SAMPLE_BITS = 24
);
  logic                          enable;
  logic                          sdo;
  logic                          sck;
  logic                          ws;
  logic signed [SAMPLE_BITS-1:0] sample;
  logic [15:0]                   sample_16;
  logic                          sample_valid;
  logic                          running;

  modport master (
    input  enable, sdo,
    output sck, ws, sample, sample_16, sample_valid, running
  );

  modport slave (
    output enable, sdo,
    input  sck, ws, sample, sample_16, sample_valid, running
  );
endinterface

// File: rtl/i2s_mic_rx_ctrl.sv
// Master-mode I2S receive controller for an INMP441-class MEMS microphone.
// Generates sck/ws from clk, shifts in sdo for the selected slot and emits
// one signed sample per 64-sck frame with a single-cycle valid pulse.
// After enable, STARTUP_FRAMES frames are generated but discarded while the
// mic settles. Dropping enable stops the interface at the next frame end.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : i2s_mic_rx_ctrl_if master modport (enable, sdo in;
//           sck, ws, sample, sample_16, sample_valid, running out)
module i2s_mic_rx_ctrl #(
  parameter int unsigned CLK_DIV        = 8,
  parameter int unsigned CHANNEL        = 0,
  parameter int unsigned STARTUP_FRAMES = 4,
  parameter int unsigned SAMPLE_BITS    = 24
) (
  input  logic              clk,
  input  logic              reset,
  i2s_mic_rx_ctrl_if.master bus
);

  localparam int unsigned      DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       LAST_POS  = 5'(SAMPLE_BITS);
  localparam logic             CH_SLOT   = (CHANNEL != 0);
  localparam logic [15:0]      LAST_WARM = 16'((STARTUP_FRAMES == 0) ? 0 : STARTUP_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic                   sck_q, sck_d;
  logic                   ws_q, ws_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [SAMPLE_BITS-1:0] sample_q, sample_d;
  logic                   valid_q, valid_d;

  logic       tick, rise, fall, boundary, in_window;
  logic [4:0] pos;

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    sck_d       = sck_q;
    ws_d        = ws_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    shift_d     = shift_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;

    tick      = (div_cnt_q == DIV_LAST);
    rise      = tick && !sck_q;
    fall      = tick && sck_q;
    boundary  = fall && (bit_cnt_q == 6'd63);
    pos       = bit_cnt_q[4:0];
    // pos 0 of each slot is the I2S one-bit delay; MSB arrives at pos 1.
    in_window = (bit_cnt_q[5] == CH_SLOT) && (pos != 5'd0) && (pos <= LAST_POS);

    case (state_q)
      ST_IDLE: begin
        div_cnt_d   = '0;
        sck_d       = 1'b0;
        ws_d        = 1'b0;
        bit_cnt_d   = '0;
        frame_cnt_d = '0;
        if (bus.enable) begin
          state_d = (STARTUP_FRAMES == 0) ? ST_RUN : ST_WARMUP;
        end
      end
      default: begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        if (tick) begin
          sck_d = !sck_q;
        end
        if (fall) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          ws_d      = bit_cnt_d[5];
        end
        if (rise && in_window) begin
          shift_d = (shift_q << 1) | SAMPLE_BITS'(bus.sdo);
          // Sample is taken straight from the shifter's next value so the
          // LSB captured on this rise is included and valid lags it by 1 clk.
          if ((pos == LAST_POS) && (state_q == ST_RUN)) begin
            sample_d = shift_d;
            valid_d  = 1'b1;
          end
        end
        // enable is only looked at on the frame boundary, so a drop and a
        // re-raise within one frame never interrupts the stream.
        if (boundary) begin
          if (!bus.enable) begin
            state_d = ST_IDLE;
          end else if (state_q == ST_WARMUP) begin
            if (frame_cnt_q == LAST_WARM) begin
              state_d = ST_RUN;
            end
            if (frame_cnt_q != '1) begin
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      sck_q       <= 1'b0;
      ws_q        <= 1'b0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      shift_q     <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      sck_q       <= sck_d;
      ws_q        <= ws_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      shift_q     <= shift_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.sck          = sck_q;
  assign bus.ws           = ws_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.running      = (state_q == ST_RUN);

  if (SAMPLE_BITS >= 16) begin : g_s16_slice
    assign bus.sample_16 = sample_q[SAMPLE_BITS-1 -: 16];
  end else begin : g_s16_pad
    assign bus.sample_16 = {sample_q, {(16 - SAMPLE_BITS){1'b0}}};
  end

endmodule

// File: tb/tb_i2s_mic_rx_ctrl.sv
// Bench for i2s_mic_rx_ctrl: two instances (left slot with 4 warm-up frames,
// right slot with 1) share enable and a behavioural I2S mic. The mic tracks
// slots from sck/ws like a real device and drives random noise outside the
// data window; expected samples are the words it chose for each slot.
module tb_i2s_mic_rx_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2s_mic_rx_ctrl_if #(.SAMPLE_BITS(24)) ifa ();
  i2s_mic_rx_ctrl_if #(.SAMPLE_BITS(24)) ifb ();

  assign ifb.enable = ifa.enable;
  assign ifb.sdo    = ifa.sdo;

  i2s_mic_rx_ctrl #(.CLK_DIV(8), .CHANNEL(0), .STARTUP_FRAMES(4), .SAMPLE_BITS(24))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  i2s_mic_rx_ctrl #(.CLK_DIV(8), .CHANNEL(1), .STARTUP_FRAMES(1), .SAMPLE_BITS(24))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Mic model and monitors state
  logic        rand_mode = 1'b0;
  logic [23:0] fixed_w [2];
  logic [23:0] cur_w [2];
  int idx = 0;
  logic prev_sck = 1'b0, prev_ws = 1'b0, prev_va = 1'b0, prev_vb = 1'b0;
  logic prev_run_a = 1'b0, prev_run_b = 1'b0;
  int last_rise = -1, last_ws_rise = -1, low_cnt = 0;
  int last_va = -1, last_vb = -1;
  int val_cnt_a = 0, val_cnt_b = 0;
  int run_rise_a = -1, run_rise_b = -1, run_fall_a = -1;
  int fall10_cyc = -1;
  bit mon_on = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      idx = 0;
      ifa.sdo = 1'b0;
      last_rise = -1;
      last_ws_rise = -1;
      low_cnt = 0;
      last_va = -1;
      last_vb = -1;
    end else begin
      // I2S mic: data changes after sck falls, MSB one bit after ws changes.
      if (prev_sck && !ifa.sck) begin
        if (ifa.ws != prev_ws) idx = 0;
        else idx++;
        if (idx == 1) cur_w[ifa.ws] = rand_mode ? 24'($urandom) : fixed_w[ifa.ws];
        if (!ifa.ws && idx == 10) fall10_cyc = cyc;
        ifa.sdo = (idx >= 1 && idx <= 24) ? cur_w[ifa.ws][24 - idx] : 1'($urandom);
      end
      if (mon_on) begin
        if (ifa.ws !== prev_ws)
          chk("ws_changes_on_sck_fall", {30'd0, prev_sck, ifa.sck}, 32'd2);
        if (!prev_sck && ifa.sck) begin
          if (last_rise >= 0) chk("sck_period", 32'(cyc - last_rise), 32'd16);
          last_rise = cyc;
        end
        if (!prev_ws && ifa.ws) begin
          if (last_ws_rise >= 0) chk("ws_period", 32'(cyc - last_ws_rise), 32'd1024);
          last_ws_rise = cyc;
        end
        if (prev_ws && !ifa.ws && last_ws_rise >= 0)
          chk("ws_high_time", 32'(cyc - last_ws_rise), 32'd512);
        low_cnt = ifa.sck ? 0 : low_cnt + 1;
        if (low_cnt > 32) begin
          last_rise = -1;
          last_ws_rise = -1;
        end
        if (ifa.running && !prev_run_a) run_rise_a = cyc;
        if (!ifa.running && prev_run_a) run_fall_a = cyc;
        if (ifb.running && !prev_run_b) run_rise_b = cyc;
        if (!ifa.running) last_va = -1;
        if (!ifb.running) last_vb = -1;
        if (ifa.sample_valid) begin
          val_cnt_a++;
          chk("a_valid_width", 32'(prev_va), 32'd0);
          chk("a_valid_in_run", 32'(ifa.running), 32'd1);
          chk("a_sample", 32'($unsigned(ifa.sample)), 32'(cur_w[0]));
          chk("a_sample_16", 32'(ifa.sample_16), 32'(cur_w[0][23:8]));
          if (last_va >= 0) chk("a_valid_period", 32'(cyc - last_va), 32'd1024);
          last_va = cyc;
        end
        if (ifb.sample_valid) begin
          val_cnt_b++;
          chk("b_valid_width", 32'(prev_vb), 32'd0);
          chk("b_valid_in_run", 32'(ifb.running), 32'd1);
          chk("b_sample", 32'($unsigned(ifb.sample)), 32'(cur_w[1]));
          chk("b_sample_16", 32'(ifb.sample_16), 32'(cur_w[1][23:8]));
          if (last_vb >= 0) chk("b_valid_period", 32'(cyc - last_vb), 32'd1024);
          last_vb = cyc;
        end
      end
    end
    prev_sck   = ifa.sck;
    prev_ws    = ifa.ws;
    prev_va    = ifa.sample_valid;
    prev_vb    = ifb.sample_valid;
    prev_run_a = ifa.running;
    prev_run_b = ifb.running;
  end

  task automatic wait_va(input int n);
    int tgt = val_cnt_a + n;
    for (int i = 0; i < 2200 * n && val_cnt_a < tgt; i++) step();
    chk("wait_valid_a", 32'(val_cnt_a), 32'(tgt));
  endtask

  task automatic wait_vb(input int n);
    int tgt = val_cnt_b + n;
    for (int i = 0; i < 2200 * n && val_cnt_b < tgt; i++) step();
    chk("wait_valid_b", 32'(val_cnt_b), 32'(tgt));
  endtask

  task automatic warmup_check(input string name);
    int t0;
    ifa.enable = 1'b1;
    t0 = cyc + 1;
    run_rise_a = -1;
    for (int i = 0; i < 5000 && run_rise_a < 0; i++) step();
    chk(name, 32'(run_rise_a - t0), 32'd4096);
  endtask

  typedef struct {
    logic [23:0] left;
    logic [23:0] right;
    logic [23:0] exp_a;
    logic [15:0] exp_a16;
    logic [23:0] exp_b;
    logic [15:0] exp_b16;
  } vec_t;

  initial begin
    vec_t vecs [4];
    int t0, vca, vcb, stop_ref;
    logic [3:0] acc;

    vecs[0] = '{24'h123456, 24'hABCDEF, 24'h123456, 16'h1234, 24'hABCDEF, 16'hABCD};
    vecs[1] = '{24'hFFF000, 24'h000FFF, 24'hFFF000, 16'hFFF0, 24'h000FFF, 16'h000F};
    vecs[2] = '{24'h800001, 24'h7FFFFE, 24'h800001, 16'h8000, 24'h7FFFFE, 16'h7FFF};
    vecs[3] = '{24'h000000, 24'hFFFFFF, 24'h000000, 16'h0000, 24'hFFFFFF, 16'hFFFF};

    fixed_w[0] = 24'h123456;
    fixed_w[1] = 24'hABCDEF;
    cur_w[0] = fixed_w[0];
    cur_w[1] = fixed_w[1];
    ifa.enable = 1'b0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    mon_on = 1'b1;

    // Reset and idle
    chk("reset_sample", 32'($unsigned(ifa.sample)), 32'd0);
    chk("reset_sample_16", 32'(ifa.sample_16), 32'd0);
    acc = '0;
    for (int i = 0; i < 500; i++) begin
      step();
      acc |= {ifa.sck, ifa.ws, ifa.sample_valid, ifa.running};
    end
    chk("idle_sck_ws_valid_running", 32'(acc), 32'd0);

    // Warm-up timing for both startup settings
    ifa.enable = 1'b1;
    t0 = cyc + 1;
    vca = val_cnt_a;
    run_rise_a = -1;
    run_rise_b = -1;
    for (int i = 0; i < 5000 && run_rise_a < 0; i++) step();
    chk("warmup_running_rise_a", 32'(run_rise_a - t0), 32'd4096);
    chk("warmup_running_rise_b", 32'(run_rise_b - t0), 32'd1024);
    chk("no_valid_in_warmup", 32'(val_cnt_a - vca), 32'd0);
    wait_va(1);
    chk("first_valid_time", 32'(last_va - t0), 32'd4488);

    // Fixed-word table
    for (int v = 0; v < 4; v++) begin
      fixed_w[0] = vecs[v].left;
      fixed_w[1] = vecs[v].right;
      wait_va(2);
      wait_vb(1);
      chk("tbl_a_sample", 32'($unsigned(ifa.sample)), 32'(vecs[v].exp_a));
      chk("tbl_a_sample_16", 32'(ifa.sample_16), 32'(vecs[v].exp_a16));
      chk("tbl_b_sample", 32'($unsigned(ifb.sample)), 32'(vecs[v].exp_b));
      chk("tbl_b_sample_16", 32'(ifb.sample_16), 32'(vecs[v].exp_b16));
    end

    // Randomized words, checked by the monitors
    rand_mode = 1'b1;
    wait_va(16);
    rand_mode = 1'b0;
    fixed_w[0] = 24'h123456;
    fixed_w[1] = 24'hABCDEF;
    wait_va(2);

    // Stop requested at bit 10 of a left slot
    for (int i = 0; i < 2200 && !(idx == 10 && !ifa.ws); i++) step();
    chk("found_left_bit10", 32'(idx), 32'd10);
    stop_ref = fall10_cyc;
    vca = val_cnt_a;
    vcb = val_cnt_b;
    run_fall_a = -1;
    ifa.enable = 1'b0;
    for (int i = 0; i < 1200 && run_fall_a < 0; i++) step();
    chk("stop_at_frame_boundary", 32'(run_fall_a - stop_ref), 32'd864);
    chk("stop_a_sample_delivered", 32'(val_cnt_a - vca), 32'd1);
    chk("stop_b_sample_delivered", 32'(val_cnt_b - vcb), 32'd1);
    acc = '0;
    for (int i = 0; i < 300; i++) begin
      step();
      acc |= {ifa.sck, ifa.ws, ifa.sample_valid, ifa.running};
    end
    chk("stopped_outputs_low", 32'(acc), 32'd0);
    chk("sample_held_after_stop", 32'($unsigned(ifa.sample)), 32'h123456);

    warmup_check("rewarm_running_rise");

    // Reset in the middle of a left-slot capture
    for (int i = 0; i < 2200 && !(idx == 12 && !ifa.ws); i++) step();
    chk("found_left_bit12", 32'(idx), 32'd12);
    vca = val_cnt_a;
    reset = 1'b1;
    step();
    chk("midreset_ctrl_outputs", 32'({ifa.sck, ifa.ws, ifa.sample_valid, ifa.running}), 32'd0);
    chk("midreset_sample", 32'($unsigned(ifa.sample)), 32'd0);
    chk("midreset_sample_16", 32'(ifa.sample_16), 32'd0);
    ifa.enable = 1'b0;
    step();
    reset = 1'b0;
    step();
    warmup_check("post_reset_running_rise");
    wait_va(1);
    chk("post_reset_single_valid", 32'(val_cnt_a - vca), 32'd1);
    chk("post_reset_sample", 32'($unsigned(ifa.sample)), 32'h123456);
    chk("post_reset_sample_16", 32'(ifa.sample_16), 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
